exe_muldiv_unit: RTL and testbench

//  Parametrised multiply/divide unit and HI/LO register file, attached beside the execute-stage ALU.

---
 rtl/exe_muldiv_unit_if.sv | 26 ++
 rtl/exe_muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_unit_if.sv
// rtl/exe_muldiv_unit_if.sv - request/response bundle between the execute stage and the mul/div unit
interface exe_muldiv_unit_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output in_valid, op, src_a, src_b, flush,
        input  in_ready, busy, done, dbz, hi, lo
    );

    modport slave (
        input  in_valid, op, src_a, src_b, flush,
        output in_ready, busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// rtl/exe_muldiv_unit.sv - multiply/divide unit with HI/LO registers beside the execute-stage ALU
module exe_muldiv_unit #(
    parameter int W       = 32,
    parameter int MUL_LAT = 2
) (
    input logic             clk,
    input logic             rst,
    exe_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam int CW = $clog2(W) + 1;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     r_ma;
    logic [W:0]     r_mb;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_src_a;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_zero;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_done;
    logic           r_dbz;

    logic           w_accept;
    logic           w_wr_hi;
    logic           w_wr_lo;
    logic           w_dbz;
    logic [W-1:0]   w_hi_d;
    logic [W-1:0]   w_lo_d;
    logic           w_signed_div;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [2*W-1:0] w_ma_x;
    logic [2*W-1:0] w_mb_x;
    logic [2*W-1:0] w_prod;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic [W:0]     w_diff;

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.dbz      = r_dbz;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

    // Operands are carried one bit wider so MULT and MULTU share one signed multiplier.
    assign w_ma_x = {{(W-1){r_ma[W]}}, r_ma};
    assign w_mb_x = {{(W-1){r_mb[W]}}, r_mb};
    assign w_prod = w_ma_x * w_mb_x;

    // Two's-complement negation of MIN yields MIN, which is the correct unsigned magnitude.
    assign w_signed_div = (bus.op == OP_DIV);
    assign w_a_mag = (w_signed_div && bus.src_a[W-1]) ? -bus.src_a : bus.src_a;
    assign w_b_mag = (w_signed_div && bus.src_b[W-1]) ? -bus.src_b : bus.src_b;

    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        w_dbz    = 1'b0;
        w_hi_d   = r_hi;
        w_lo_d   = r_lo;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.in_valid && (bus.op <= OP_MTLO) && !bus.flush;
                if (w_accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: w_next = S_MUL;
                        OP_DIV, OP_DIVU:   w_next = S_DIV;
                        OP_MTHI: begin
                            w_wr_hi = 1'b1;
                            w_hi_d  = bus.src_a;
                        end
                        default: begin
                            w_wr_lo = 1'b1;
                            w_lo_d  = bus.src_a;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(MUL_LAT - 1)) begin
                    w_next  = S_IDLE;
                    w_wr_hi = 1'b1;
                    w_wr_lo = 1'b1;
                    w_hi_d  = w_prod[2*W-1:W];
                    w_lo_d  = w_prod[W-1:0];
                end
            end
            S_DIV: begin
                if (r_cnt == CW'(W - 1)) begin
                    w_next = S_FIX;
                end
            end
            default: begin
                w_next  = S_IDLE;
                w_wr_hi = 1'b1;
                w_wr_lo = 1'b1;
                if (r_zero) begin
                    w_dbz  = 1'b1;
                    w_lo_d = {W{1'b1}};
                    w_hi_d = r_src_a;
                end else begin
                    w_lo_d = r_neg_q ? -r_quo : r_quo;
                    w_hi_d = r_neg_r ? -r_rem : r_rem;
                end
            end
        endcase
        // Flush kills whatever write or transition this edge would have made.
        if (bus.flush) begin
            w_next  = S_IDLE;
            w_wr_hi = 1'b0;
            w_wr_lo = 1'b0;
            w_dbz   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_src_a <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= w_wr_hi || w_wr_lo;
            r_dbz  <= w_dbz;
            if (w_wr_hi) begin
                r_hi <= w_hi_d;
            end
            if (w_wr_lo) begin
                r_lo <= w_lo_d;
            end
            if (w_accept) begin
                r_cnt   <= '0;
                r_ma    <= {(bus.op == OP_MULT) && bus.src_a[W-1], bus.src_a};
                r_mb    <= {(bus.op == OP_MULT) && bus.src_b[W-1], bus.src_b};
                r_quo   <= w_a_mag;
                r_rem   <= '0;
                r_dvs   <= w_b_mag;
                r_src_a <= bus.src_a;
                r_neg_q <= w_signed_div && (bus.src_a[W-1] ^ bus.src_b[W-1]);
                r_neg_r <= w_signed_div && bus.src_a[W-1];
                r_zero  <= (bus.src_b == '0);
            end else if (r_state == S_MUL) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_DIV) begin
                r_cnt <= r_cnt + 1'b1;
                r_quo <= {r_quo[W-2:0], w_ge};
                r_rem <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb/tb_exe_muldiv_unit.sv - scoreboard bench for exe_muldiv_unit with directed vectors
module tb_exe_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t q_exp[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    exe_muldiv_unit_if #(.W(W)) bus ();

    exe_muldiv_unit #(.W(W), .MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.done) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check("mon_hi", 64'(bus.hi), 64'(e.hi));
                    check("mon_lo", 64'(bus.lo), 64'(e.lo));
                    check("mon_dbz", 64'(bus.dbz), 64'(e.dbz));
                end
            end else if (bus.dbz) begin
                check("dbz_without_done", 64'(bus.dbz), 64'd0);
            end
        end
    end

    task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.dbz = dbz;
        q_exp.push_back(e);
        m_hi = hi;
        m_lo = lo;
    endtask

    // Called just after a posedge; returns just after the acceptance edge (cycle 1).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz, input int lat);
        int n;
        issue(op, a, b);
        push(ehi, elo, edbz);
        n = 1;
        @(negedge clk);
        while (!bus.done && n < 60) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_hi = '0;
        m_lo = '0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 3);
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, 3);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
        run_op("divu_dbz", 3'd3, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 34);
        run_op("div_dbz_neg", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 34);
        run_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34);
        run_op("divu_big", 3'd3, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34);
        run_op("mthi", 3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'h0FFFFFFF, 1'b0, 1);

        // MTHI then MTLO on consecutive cycles
        bus.in_valid = 1'b1;
        bus.op = 3'd4;
        bus.src_a = 32'hDEADBEEF;
        push(32'hDEADBEEF, m_lo, 1'b0);
        @(posedge clk);
        #1;
        bus.op = 3'd5;
        bus.src_a = 32'hCAFEBABE;
        push(m_hi, 32'hCAFEBABE, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // flush during DIV at cycle 10
        issue(3'd2, 32'd100, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_div_busy", 64'(bus.busy), 64'd0);
        check("flush_div_hi", 64'(bus.hi), 64'(m_hi));
        check("flush_div_lo", 64'(bus.lo), 64'(m_lo));
        @(posedge clk);
        #1;
        run_op("mult_after_flush", 3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 3);

        // MTLO held while MULT is busy
        issue(3'd0, 32'd2, 32'd3);
        push(32'd0, 32'd6, 1'b0);
        bus.in_valid = 1'b1;
        bus.op = 3'd5;
        bus.src_a = 32'h0000A5A5;
        @(negedge clk);
        check("held_ready_c1", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("held_ready_c2", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("held_ready_c3", 64'(bus.in_ready), 64'd1);
        push(32'd0, 32'h0000A5A5, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("held_lo_c4", 64'(bus.lo), 64'h0000A5A5);
        @(posedge clk);
        #1;

        // flush on the MULT write edge
        issue(3'd0, 32'd7, 32'd7);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("flush_mul_lo", 64'(bus.lo), 64'(m_lo));
        check("flush_mul_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;

        // reset mid-DIV at cycle 5
        issue(3'd3, 32'd1000, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("rstdiv_hi", 64'(bus.hi), 64'd0);
        check("rstdiv_lo", 64'(bus.lo), 64'd0);
        check("rstdiv_busy", 64'(bus.busy), 64'd0);
        check("rstdiv_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;

        // reserved opcodes never accepted
        run_op("mthi_pre", 3'd4, 32'h00000055, 32'd0, 32'h00000055, 32'd0, 1'b0, 1);
        bus.in_valid = 1'b1;
        bus.src_a = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            bus.op = (i < 2) ? 3'd6 : 3'd7;
            @(negedge clk);
            check("reserved_busy", 64'(bus.busy), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("reserved_hi", 64'(bus.hi), 64'h00000055);
        check("reserved_lo", 64'(bus.lo), 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", 64'(q_exp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
